// File: rtl/flash_phy_rd_descramble.sv
// Per-bank read-path descramble sequencer: obtains the XEX mask, runs the shared cipher and presents plaintext.
// Optional handshake watchdog is enabled by defining FLASH_PHY_RD_DESCRAMBLE_WDOG_EN.
module flash_phy_rd_descramble #(
   parameter int DataWidth     = 64,
   parameter int BankAddrW     = 17,
   parameter int TimeoutCycles = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [BankAddrW-1:0] in_addr_i,
   input  logic [DataWidth-1:0] in_data_i,
   input  logic                 in_scr_en_i,
   output logic                 calc_req_o,
   output logic [BankAddrW-1:0] calc_addr_o,
   input  logic                 calc_ack_i,
   input  logic [DataWidth-1:0] mask_i,
   output logic                 op_req_o,
   output logic                 op_type_o,
   output logic [DataWidth-1:0] op_data_o,
   input  logic                 op_ack_i,
   input  logic [DataWidth-1:0] op_plain_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 out_err_o,
   output logic                 err_o
);

   localparam logic DeScrambleOp = 1'b1;

   typedef enum logic [1:0] {StIdle, StCalc, StOp, StOut} state_e;

   state_e               state_q, state_d;
   logic [BankAddrW-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic [DataWidth-1:0] mask_q, mask_d;
   logic                 timeout;

`ifdef FLASH_PHY_RD_DESCRAMBLE_WDOG_EN
   localparam int CntW = $clog2(TimeoutCycles);

   logic [CntW-1:0] cnt_q;
   logic            out_err_q, err_q;
   logic            wdog_fire;

   // Counter restarts on every state change, so it measures time spent waiting in CALC/OP.
   assign timeout   = (cnt_q == CntW'(TimeoutCycles - 1));
   assign wdog_fire = timeout && ((state_q == StCalc && !calc_ack_i) ||
                                  (state_q == StOp   && !op_ack_i));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         out_err_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cnt_q <= (state_d != state_q) ? '0 : cnt_q + CntW'(1);
         if (wdog_fire) begin
            out_err_q <= 1'b1;
            err_q     <= 1'b1;
         end else if (state_q == StOut && out_ready_i) begin
            out_err_q <= 1'b0;
         end
      end
   end

   assign out_err_o = out_err_q;
   assign err_o     = err_q;
`else
   assign timeout   = 1'b0;
   assign out_err_o = 1'b0;
   assign err_o     = 1'b0;
`endif

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      mask_d  = mask_q;
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               addr_d  = in_addr_i;
               data_d  = in_data_i;
               state_d = in_scr_en_i ? StCalc : StOut;
            end
         end
         StCalc: begin
            if (calc_ack_i) begin
               mask_d  = mask_i;
               state_d = StOp;
            end else if (timeout) begin
               data_d  = '0;
               state_d = StOut;
            end
         end
         StOp: begin
            if (op_ack_i) begin
               data_d  = op_plain_i ^ mask_q;
               state_d = StOut;
            end else if (timeout) begin
               data_d  = '0;
               state_d = StOut;
            end
         end
         StOut: begin
            if (out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   // Outputs decode straight from the state register, so an async reset drops requests immediately.
   assign in_ready_o  = (state_q == StIdle);
   assign calc_req_o  = (state_q == StCalc);
   assign calc_addr_o = (state_q == StCalc) ? addr_q : '0;
   assign op_req_o    = (state_q == StOp);
   assign op_type_o   = (state_q == StOp) ? DeScrambleOp : 1'b0;
   assign op_data_o   = (state_q == StOp) ? (data_q ^ mask_q) : '0;
   assign out_valid_o = (state_q == StOut);
   assign out_data_o  = (state_q == StOut) ? data_q : '0;

endmodule

// File: tb/tb_flash_phy_rd_descramble.sv
// Self-checking bench for flash_phy_rd_descramble; the bench plays the shared scramble unit and the consumer.
// Watchdog expectations follow FLASH_PHY_RD_DESCRAMBLE_WDOG_EN when it is defined.
module tb_flash_phy_rd_descramble;

   localparam int DW = 64;
   localparam int AW = 17;
   localparam int TO = 64;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [AW-1:0] in_addr_i = '0;
   logic [DW-1:0] in_data_i = '0;
   logic          in_scr_en_i = 1'b0;
   logic          calc_req_o;
   logic [AW-1:0] calc_addr_o;
   logic          calc_ack_i = 1'b0;
   logic [DW-1:0] mask_i = '0;
   logic          op_req_o;
   logic          op_type_o;
   logic [DW-1:0] op_data_o;
   logic          op_ack_i = 1'b0;
   logic [DW-1:0] op_plain_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [DW-1:0] out_data_o;
   logic          out_err_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   flash_phy_rd_descramble #(.DataWidth(DW), .BankAddrW(AW), .TimeoutCycles(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
      .in_data_i(in_data_i), .in_scr_en_i(in_scr_en_i),
      .calc_req_o(calc_req_o), .calc_addr_o(calc_addr_o), .calc_ack_i(calc_ack_i), .mask_i(mask_i),
      .op_req_o(op_req_o), .op_type_o(op_type_o), .op_data_o(op_data_o),
      .op_ack_i(op_ack_i), .op_plain_i(op_plain_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_err_o(out_err_o), .err_o(err_o)
   );

   // Reference model: what the read path must deliver for one beat.
   function automatic logic [DW-1:0] model_out(input bit scr, input logic [DW-1:0] raw,
                                               input logic [DW-1:0] mask, input logic [DW-1:0] plain);
      return scr ? (plain ^ mask) : raw;
   endfunction

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Drives one beat through the DUT acting as scramble unit and consumer; returns observations.
   // Latencies are counted in negedges after the triggering event (1 = next cycle, -1 = never).
   task automatic do_beat(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit scr,
                          input logic [DW-1:0] mask, input logic [DW-1:0] plain,
                          input int calc_dly, input int op_dly, input int out_dly, input bit poke,
                          output logic [DW-1:0] got_op, output logic [DW-1:0] got_out,
                          output int calc_lat, output int op_lat, output int out_lat,
                          output bit stable);
      int n;
      stable = 1'b1; calc_lat = 0; op_lat = 0; out_lat = 0; got_op = '0; got_out = '0;
      n = 0;
      while (!in_ready_o && n < 20) begin @(negedge clk_i); n++; end
      in_valid_i = 1'b1; in_addr_i = addr; in_data_i = data; in_scr_en_i = scr;
      @(negedge clk_i);
      in_valid_i = 1'b0; in_addr_i = AW'($urandom); in_data_i = rnd64(); in_scr_en_i = 1'($urandom);
      if (scr) begin
         n = 1;
         while (!calc_req_o && n < 20) begin @(negedge clk_i); n++; end
         calc_lat = calc_req_o ? n : -1;
         for (int i = 0; i < calc_dly; i++) begin
            if (!(calc_req_o === 1'b1 && calc_addr_o === addr && op_req_o === 1'b0 && out_valid_o === 1'b0))
               stable = 1'b0;
            @(negedge clk_i);
         end
         if (calc_req_o !== 1'b1 || calc_addr_o !== addr) stable = 1'b0;
         calc_ack_i = 1'b1; mask_i = mask;
         @(negedge clk_i);
         calc_ack_i = 1'b0; mask_i = rnd64();
         n = 1;
         while (!op_req_o && n < 20) begin @(negedge clk_i); n++; end
         op_lat = op_req_o ? n : -1;
         got_op = op_data_o;
         for (int i = 0; i < op_dly; i++) begin
            if (!(op_req_o === 1'b1 && op_type_o === 1'b1 && op_data_o === got_op && calc_req_o === 1'b0))
               stable = 1'b0;
            @(negedge clk_i);
         end
         if (op_req_o !== 1'b1 || op_data_o !== got_op) stable = 1'b0;
         op_ack_i = 1'b1; op_plain_i = plain;
         @(negedge clk_i);
         op_ack_i = 1'b0; op_plain_i = rnd64();
      end
      n = 1;
      while (!out_valid_o && n < 20) begin @(negedge clk_i); n++; end
      out_lat = out_valid_o ? n : -1;
      got_out = out_data_o;
      if (poke) begin in_valid_i = 1'b1; in_data_i = rnd64(); in_scr_en_i = 1'b0; end
      for (int i = 0; i < out_dly; i++) begin
         if (!(out_valid_o === 1'b1 && out_data_o === got_out && in_ready_o === 1'b0)) stable = 1'b0;
         if (!scr && (calc_req_o || op_req_o)) stable = 1'b0;
         @(negedge clk_i);
      end
      if (!scr && (calc_req_o || op_req_o)) stable = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0; in_valid_i = 1'b0;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) stable = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({calc_req_o, op_req_o, out_valid_o, out_err_o, err_o} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b required 00000", {calc_req_o, op_req_o, out_valid_o, out_err_o, err_o});
      end
      checks++;
      if (out_data_o !== '0 || op_data_o !== '0 || calc_addr_o !== '0) begin
         errors++; $display("FAIL reset_data: out %h op %h addr %h required 0", out_data_o, op_data_o, calc_addr_o);
      end
      rst_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready_o); end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] d, got_op, got_out;
      int cl, ol, wl;
      bit st;
      d = 64'hDEADBEEF_CAFEF00D;
      do_beat(AW'($urandom), d, 1'b0, rnd64(), rnd64(), 0, 0, 2, 1'b0, got_op, got_out, cl, ol, wl, st);
      checks++;
      if (got_out !== model_out(1'b0, d, '0, '0)) begin
         errors++; $display("FAIL bypass_data: got %h required %h", got_out, d);
      end
      checks++;
      if (wl !== 1) begin errors++; $display("FAIL bypass_latency: got %0d required 1", wl); end
      checks++;
      if (!st) begin errors++; $display("FAIL bypass_no_req: requests asserted or output unstable"); end
   endtask

   task automatic test_scrambled();
      logic [DW-1:0] got_op, got_out;
      int cl, ol, wl;
      bit st;
      do_beat(AW'(17'h00123), {DW{1'b1}}, 1'b1, {8{8'h0F}}, {8{8'h11}}, 0, 0, 0, 1'b0,
              got_op, got_out, cl, ol, wl, st);
      checks++;
      if (got_op !== {8{8'hF0}}) begin errors++; $display("FAIL scr_op_data: got %h required %h", got_op, {8{8'hF0}}); end
      checks++;
      if (got_out !== {8{8'h1E}}) begin errors++; $display("FAIL scr_out_data: got %h required %h", got_out, {8{8'h1E}}); end
      checks++;
      if (cl !== 1 || ol !== 1 || wl !== 1) begin
         errors++; $display("FAIL scr_latency: calc %0d op %0d out %0d required 1 1 1", cl, ol, wl);
      end
      checks++;
      if (!st) begin errors++; $display("FAIL scr_stable: handshake signals unstable"); end
   endtask

   task automatic test_delayed_acks();
      logic [DW-1:0] d, m, p, got_op, got_out;
      logic [AW-1:0] a;
      int cl, ol, wl, extra;
      bit st;
      a = AW'($urandom); d = rnd64(); m = rnd64(); p = rnd64();
      do_beat(a, d, 1'b1, m, p, 10, 7, 0, 1'b0, got_op, got_out, cl, ol, wl, st);
      checks++;
      if (!st) begin errors++; $display("FAIL delayed_stable: request/address/data moved while waiting"); end
      checks++;
      if (got_op !== (d ^ m)) begin errors++; $display("FAIL delayed_op_data: got %h required %h", got_op, d ^ m); end
      checks++;
      if (got_out !== model_out(1'b1, d, m, p)) begin
         errors++; $display("FAIL delayed_out: got %h required %h", got_out, model_out(1'b1, d, m, p));
      end
      extra = 0;
      out_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin @(negedge clk_i); if (out_valid_o) extra++; end
      out_ready_i = 1'b0;
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL delayed_single: got %0d extra beats required 0", extra); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d, m, p, got_op, got_out;
      int cl, ol, wl;
      bit st;
      d = rnd64(); m = rnd64(); p = rnd64();
      do_beat(AW'($urandom), d, 1'b1, m, p, 1, 1, 5, 1'b1, got_op, got_out, cl, ol, wl, st);
      checks++;
      if (!st) begin errors++; $display("FAIL bp_hold: output not held or input accepted under backpressure"); end
      checks++;
      if (got_out !== model_out(1'b1, d, m, p)) begin
         errors++; $display("FAIL bp_data: got %h required %h", got_out, model_out(1'b1, d, m, p));
      end
      // The poked beat must have been refused: a follow-up bypass beat is the next and only result.
      d = rnd64();
      do_beat(AW'($urandom), d, 1'b0, '0, '0, 0, 0, 0, 1'b0, got_op, got_out, cl, ol, wl, st);
      checks++;
      if (got_out !== d || wl !== 1) begin
         errors++; $display("FAIL bp_next_beat: got %h lat %0d required %h lat 1", got_out, wl, d);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] d, m, p, got_op, got_out, exp;
      int cl, ol, wl, bad;
      bit scr, st;
      bad = 0;
      for (int k = 0; k < 24; k++) begin
         d = rnd64(); m = rnd64(); p = rnd64(); scr = 1'($urandom);
         do_beat(AW'($urandom), d, scr, m, p, $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 3), 1'($urandom), got_op, got_out, cl, ol, wl, st);
         exp = model_out(scr, d, m, p);
         checks++;
         if (got_out !== exp || !st || (scr && got_op !== (d ^ m))) begin
            errors++;
            $display("FAIL random_beat %0d: scr %0d out %h op %h stable %0d required out %h op %h",
                     k, scr, got_out, got_op, st, exp, d ^ m);
         end
      end
   endtask

   task automatic test_stray_ack();
      calc_ack_i = 1'b1; op_ack_i = 1'b1; mask_i = rnd64(); op_plain_i = rnd64();
      @(negedge clk_i);
      calc_ack_i = 1'b0; op_ack_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({in_ready_o, calc_req_o, op_req_o, out_valid_o} !== 4'b1000) begin
         errors++; $display("FAIL stray_ack: got %b required 1000", {in_ready_o, calc_req_o, op_req_o, out_valid_o});
      end
   endtask

   task automatic test_reset_mid_op();
      logic [DW-1:0] d, got_op, got_out;
      int cl, ol, wl, n;
      bit st;
      in_valid_i = 1'b1; in_scr_en_i = 1'b1; in_data_i = rnd64(); in_addr_i = AW'($urandom);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      calc_ack_i = 1'b1; mask_i = rnd64();
      @(negedge clk_i);
      calc_ack_i = 1'b0;
      n = 0;
      while (!op_req_o && n < 10) begin @(negedge clk_i); n++; end
      checks++;
      if (op_req_o !== 1'b1) begin errors++; $display("FAIL midop_reach: op_req got %b required 1", op_req_o); end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (op_req_o !== 1'b0 || out_valid_o !== 1'b0) begin
         errors++; $display("FAIL midop_async_drop: op_req %b out_valid %b required 0 0", op_req_o, out_valid_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      d = rnd64();
      do_beat(AW'($urandom), d, 1'b0, '0, '0, 0, 0, 0, 1'b0, got_op, got_out, cl, ol, wl, st);
      checks++;
      if (got_out !== d || wl !== 1 || !st) begin
         errors++; $display("FAIL midop_recover: got %h lat %0d required %h lat 1", got_out, wl, d);
      end
   endtask

   task automatic test_watchdog();
      int req_cycles, n;
      in_valid_i = 1'b1; in_scr_en_i = 1'b1; in_data_i = rnd64(); in_addr_i = AW'($urandom);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      req_cycles = 0; n = 0;
      while (!out_valid_o && n < 200) begin
         if (calc_req_o) req_cycles++;
         @(negedge clk_i); n++;
      end
`ifdef FLASH_PHY_RD_DESCRAMBLE_WDOG_EN
      checks++;
      if (req_cycles !== TO || out_valid_o !== 1'b1) begin
         errors++; $display("FAIL wdog_timeout: req cycles %0d valid %b required %0d 1", req_cycles, out_valid_o, TO);
      end
      checks++;
      if (out_data_o !== '0 || out_err_o !== 1'b1 || err_o !== 1'b1 || calc_req_o !== 1'b0) begin
         errors++; $display("FAIL wdog_result: data %h out_err %b err %b req %b required 0 1 1 0",
                            out_data_o, out_err_o, err_o, calc_req_o);
      end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      calc_ack_i = 1'b1; mask_i = rnd64();
      @(negedge clk_i);
      calc_ack_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_err_o !== 1'b0 || err_o !== 1'b1) begin
         errors++; $display("FAIL wdog_late_ack: ready %b valid %b out_err %b err %b required 1 0 0 1",
                            in_ready_o, out_valid_o, out_err_o, err_o);
      end
`else
      checks++;
      if (calc_req_o !== 1'b1 || req_cycles !== 200 || out_valid_o !== 1'b0) begin
         errors++; $display("FAIL nowdog_hold: req %b cycles %0d valid %b required 1 200 0",
                            calc_req_o, req_cycles, out_valid_o);
      end
      checks++;
      if (err_o !== 1'b0 || out_err_o !== 1'b0) begin
         errors++; $display("FAIL nowdog_err: err %b out_err %b required 0 0", err_o, out_err_o);
      end
      calc_ack_i = 1'b1; mask_i = rnd64();
      @(negedge clk_i);
      calc_ack_i = 1'b0;
      op_ack_i = 1'b1;
      @(negedge clk_i);
      op_ack_i = 1'b0;
      @(negedge clk_i);
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL nowdog_drain: ready %b required 1", in_ready_o); end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_bypass();
      test_scrambled();
      test_delayed_acks();
      test_backpressure();
      test_stray_ack();
      test_random();
      test_reset_mid_op();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
